demux_1to2_buffered: RTL

- Inverse of the ALU's 16-bit 2:1 operand/result mux: one input stream is steered to one of two output streams.
- Each output has its own small FIFO, so a stalled destination never corrupts or drops data and only blocks traffic aimed at itself.
- Sits between the ALU result stage and two consumers, for example the register writeback and the flag/status path.
- Select encoding matches the mux: select=0 routes to out1, select=1 routes to out2.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_fifo.sv | 65 ++++++
 rtl/demux_1to2_buffered.sv | 79 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults, select encoding and FIFO occupancy width helper.
`default_nettype none

package demux_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  // One extra bit so occupancy can represent DEPTH itself.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/demux_fifo.sv
// demux_fifo: synchronous FIFO, registered occupancy, head held when drained.
`default_nettype none

module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic [WIDTH-1:0] hold_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (occ_q == OW'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  // Once drained, keep presenting the word that was popped last.
  assign head_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    if (w_push && !w_pop) occ_d = occ_q + 1'b1;
    else if (!w_push && w_pop) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      hold_q   <= '0;
    end else begin
      occ_q <= occ_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/demux_1to2_buffered.sv
// demux_1to2_buffered: steers one stream into two independently buffered outputs.
`default_nettype none

module demux_1to2_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  logic             full1, full2, empty1, empty2;
  logic             w_acc, w_push1, w_push2;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  // Ready looks only at registered fullness: a same-cycle pop never frees a slot.
  assign in_ready = rst_n & ((select == SEL_OUT1) ? ~full1 : ~full2);
  assign w_acc    = in_valid & in_ready;
  assign w_push1  = w_acc & (select == SEL_OUT1);
  assign w_push2  = w_acc & (select == SEL_OUT2);

  assign out1_valid = ~empty1;
  assign out2_valid = ~empty2;
  assign cnt1       = cnt1_q;
  assign cnt2       = cnt2_q;

  always_comb begin
    cnt1_d = cnt1_q + CNT_W'(w_push1);
    cnt2_d = cnt2_q + CNT_W'(w_push2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (w_push1),
    .data_i (in_data),
    .pop_i  (out1_ready),
    .full_o (full1),
    .empty_o(empty1),
    .head_o (out1_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (w_push2),
    .data_i (in_data),
    .pop_i  (out2_ready),
    .full_o (full2),
    .empty_o(empty2),
    .head_o (out2_data)
  );
endmodule

`default_nettype wire
